// File: rtl/frq_meter_pkg.sv
// Shared constants and state encoding for the frequency meter.
package frq_meter_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

endpackage

// File: rtl/frq_meter_if.sv
// Measurement control and result bundle between the meter and its user.
interface frq_meter_if;

    logic       en;
    logic       sig_in;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       ovf;
    logic       valid;

    modport master (
        output en,
        output sig_in,
        input  bcd_tens,
        input  bcd_ones,
        input  ovf,
        input  valid
    );

    modport slave (
        input  en,
        input  sig_in,
        output bcd_tens,
        output bcd_ones,
        output ovf,
        output valid
    );

endinterface

// File: rtl/frq_meter_bcd_cnt2.sv
// Two-digit BCD counter that saturates at 99 and flags the saturation.
// The next-value outputs let the owner capture the count including the
// increment of the cycle in which it clears the counter.
module bcd_cnt2
    import frq_meter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       sat,
    output logic [3:0] nxt_tens,
    output logic [3:0] nxt_ones,
    output logic       nxt_sat
);

    // Increment with ones-to-tens carry; hold at 99 and flag sat beyond it.
    always_comb begin
        nxt_tens = tens;
        nxt_ones = ones;
        nxt_sat  = sat;
        if (inc) begin
            if (ones == BCD_MAX_DIGIT && tens == BCD_MAX_DIGIT) begin
                nxt_sat = 1'b1;
            end else if (ones == BCD_MAX_DIGIT) begin
                nxt_ones = 4'd0;
                nxt_tens = tens + 4'd1;
            end else begin
                nxt_ones = ones + 4'd1;
            end
        end
    end

    // Running count register; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
            sat  <= 1'b0;
        end else if (clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
            sat  <= 1'b0;
        end else begin
            tens <= nxt_tens;
            ones <= nxt_ones;
            sat  <= nxt_sat;
        end
    end

endmodule

// File: rtl/frq_meter.sv
// Counts rising edges of an asynchronous input over back-to-back gate
// windows and publishes each window's count as two BCD digits.
//
// state | meaning
// IDLE  | not measuring; running count held clear, outputs hold last result
// GATE  | counting edges inside a gate window
module frq_meter
    import frq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int GATE_W      = 10
)
(
    input  logic        clk,
    input  logic        rst,
    frq_meter_if.slave  bus
);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic              s1, s2, prev;
    logic              sig_edge;
    state_t            state, state_nxt;
    logic [GATE_W-1:0] gate_cnt;
    logic              terminal;
    logic              clr;
    logic              inc;
    logic [3:0]        run_tens, run_ones;
    logic              run_sat;
    logic [3:0]        nxt_tens, nxt_ones;
    logic              nxt_sat;
    logic [3:0]        out_tens, out_ones;
    logic              out_ovf, out_valid;

    // Two-flop synchronizer plus history flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= bus.sig_in;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign sig_edge = s2 & ~prev;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and counter control; the terminal cycle publishes even if en falls.
    always_comb begin
        state_nxt = state;
        terminal  = 1'b0;
        clr       = 1'b1;
        inc       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en) state_nxt = GATE;
            end
            GATE: begin
                terminal = (gate_cnt == GATE_LAST);
                inc      = sig_edge;
                clr      = terminal | ~bus.en;
                if (!bus.en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gate counter wraps at the terminal cycle so windows run back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt <= '0;
        end else if (state == GATE && bus.en && !terminal) begin
            gate_cnt <= gate_cnt + 1'b1;
        end else begin
            gate_cnt <= '0;
        end
    end

    bcd_cnt2 u_bcd (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .inc      (inc),
        .tens     (run_tens),
        .ones     (run_ones),
        .sat      (run_sat),
        .nxt_tens (nxt_tens),
        .nxt_ones (nxt_ones),
        .nxt_sat  (nxt_sat)
    );

    // Result capture at window close, using the count including this cycle's edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_tens  <= 4'd0;
            out_ones  <= 4'd0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= terminal;
            if (terminal) begin
                out_tens <= nxt_tens;
                out_ones <= nxt_ones;
                out_ovf  <= nxt_sat;
            end
        end
    end

    assign bus.bcd_tens = out_tens;
    assign bus.bcd_ones = out_ones;
    assign bus.ovf      = out_ovf;
    assign bus.valid    = out_valid;

endmodule

// File: tb/tb_frq_meter.sv
// Directed bench for frq_meter: a 60-cycle and a 300-cycle gate instance
// share the stimulus; expected digits and timings are hand-derived.
module tb_frq_meter;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sig;
    int   half;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    frq_meter_if bus60 ();
    frq_meter_if bus300 ();

    assign bus60.en      = en;
    assign bus60.sig_in  = sig;
    assign bus300.en     = en;
    assign bus300.sig_in = sig;

    frq_meter #(.GATE_CYCLES(60), .GATE_W(6)) dut60 (
        .clk (clk),
        .rst (rst),
        .bus (bus60)
    );

    frq_meter #(.GATE_CYCLES(300), .GATE_W(9)) dut300 (
        .clk (clk),
        .rst (rst),
        .bus (bus300)
    );

    // Square-wave source: toggles every 'half' cycles; idle when half is 0.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (half != 0) begin
                ph++;
                if (ph >= half) begin
                    sig = ~sig;
                    ph  = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits for the next valid pulse (bounded), checks the result, then checks the pulse is one cycle.
    task automatic next_window(input bit big, input int budget, input string tag, input bit do_chk,
                               input int exp_t, input int exp_o, input int exp_ovf, input int exp_cyc);
        int         cyc;
        bit         got;
        logic [3:0] t, o;
        logic       v, f;
        cyc = 0;
        got = 0;
        while (!got && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            got = big ? bus300.valid : bus60.valid;
        end
        t = big ? bus300.bcd_tens : bus60.bcd_tens;
        o = big ? bus300.bcd_ones : bus60.bcd_ones;
        f = big ? bus300.ovf : bus60.ovf;
        chk({tag, "_seen"}, got, 1);
        chk({tag, "_digit_range"}, (t <= 4'd9 && o <= 4'd9), 1);
        if (got && do_chk) begin
            chk({tag, "_tens"}, t, exp_t);
            chk({tag, "_ones"}, o, exp_o);
            chk({tag, "_ovf"}, f, exp_ovf);
            if (exp_cyc > 0) chk({tag, "_latency"}, cyc, exp_cyc);
        end
        @(posedge clk);
        #1;
        v = big ? bus300.valid : bus60.valid;
        chk({tag, "_pulse_width"}, v, 0);
    endtask

    initial begin
        bit seen;
        rst  = 1'b1;
        en   = 1'b0;
        sig  = 1'b0;
        half = 0;
        repeat (3) @(negedge clk);
        chk("rst_tens", bus60.bcd_tens, 0);
        chk("rst_ones", bus60.bcd_ones, 0);
        chk("rst_ovf", bus60.ovf, 0);
        chk("rst_valid", bus60.valid, 0);
        chk("rst_big_valid", bus300.valid, 0);

        // Edge landing exactly in the terminal cycle belongs to the closing window.
        rst = 1'b0;
        en  = 1'b1;
        repeat (58) @(posedge clk);
        @(negedge clk);
        sig = 1'b1;
        next_window(0, 100, "term_edge", 1, 0, 1, 0, 0);
        next_window(0, 100, "term_edge_next", 1, 0, 0, 0, 59);

        // Input high through reset gives one edge after release, then nothing.
        @(negedge clk);
        rst = 1'b1;
        sig = 1'b1;
        repeat (3) @(negedge clk);
        chk("hi_rst_hold_valid", bus60.valid, 0);
        chk("hi_rst_hold_tens", bus60.bcd_tens, 0);
        rst = 1'b0;
        next_window(0, 100, "hi_rst", 1, 0, 1, 0, 61);
        next_window(0, 100, "hi_rst_next", 1, 0, 0, 0, 59);
        @(negedge clk);
        sig = 1'b0;
        next_window(0, 100, "low", 1, 0, 0, 0, 59);

        // Period 6: ten edges per 60-cycle window.
        half = 3;
        next_window(0, 100, "p6_warm", 0, 0, 0, 0, 0);
        repeat (3) next_window(0, 100, "p6", 1, 1, 0, 0, 59);

        // Enable dropped at gate cycle 30: partial window discarded, outputs hold.
        repeat (29) @(posedge clk);
        @(negedge clk);
        en   = 1'b0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus60.valid) seen = 1;
        end
        chk("en_drop_no_valid", seen, 0);
        chk("en_drop_hold_tens", bus60.bcd_tens, 1);
        chk("en_drop_hold_ones", bus60.bcd_ones, 0);
        @(negedge clk);
        en = 1'b1;
        next_window(0, 100, "reenable", 1, 1, 0, 0, 61);

        // Reset mid-window clears outputs at once; counting restarts from zero.
        repeat (33) @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        half = 0;
        sig  = 1'b0;
        #1;
        chk("mid_rst_tens", bus60.bcd_tens, 0);
        chk("mid_rst_ones", bus60.bcd_ones, 0);
        chk("mid_rst_ovf", bus60.ovf, 0);
        chk("mid_rst_valid", bus60.valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        next_window(0, 100, "post_rst", 1, 0, 0, 0, 61);

        // Period 2: thirty edges per 60-cycle window.
        half = 1;
        next_window(0, 100, "p2_warm", 0, 0, 0, 0, 0);
        repeat (2) next_window(0, 100, "p2", 1, 3, 0, 0, 59);

        // 300-cycle gate: 150 edges saturates at 99 with ovf, then 50 at period 6.
        next_window(1, 400, "big_warm", 0, 0, 0, 0, 0);
        next_window(1, 400, "big_sat", 1, 9, 9, 1, 299);
        half = 3;
        next_window(1, 400, "big_warm2", 0, 0, 0, 0, 0);
        next_window(1, 400, "big_p6", 1, 5, 0, 0, 299);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
